// File: rtl/calc_ctrl.sv
// Keypad sequencer in front of the 8-bit ALU: builds two decimal operands,
// issues one operation per '=' and registers the result and flags for display.
module calc_ctrl #(
  parameter int unsigned MAX_DIGITS  = 3,
  parameter bit          CHAIN_CARRY = 1'b0
) (
  input  logic       IN_clk,
  input  logic       IN_rst_n,
  input  logic       IN_clr,
  input  logic       IN_key_valid,
  input  logic [3:0] IN_key,
  input  logic [7:0] IN_alu_S,
  input  logic       IN_alu_zero,
  input  logic       IN_alu_carry,
  output logic [3:0] OUT_alu_cs,
  output logic [7:0] OUT_alu_a,
  output logic [7:0] OUT_alu_b,
  output logic       OUT_alu_cin,
  output logic [7:0] OUT_disp,
  output logic       OUT_neg,
  output logic       OUT_lt,
  output logic       OUT_zero,
  output logic       OUT_carry,
  output logic       OUT_err,
  output logic       OUT_busy,
  output logic       OUT_done
);

  localparam logic [3:0] OpAdd = 4'hA;
  localparam logic [3:0] OpSub = 4'hB;
  localparam logic [3:0] OpCmp = 4'hE;

  typedef enum logic [1:0] {StEntryA, StEntryB, StExec, StResult} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0] op_q, op_d, cs_q, cs_d, cnt_q, cnt_d;
  logic       cin_q, cin_d, chain_q, chain_d;
  logic       neg_q, neg_d, lt_q, lt_d, zero_q, zero_d, carry_q, carry_d;
  logic       err_q, err_d, done_q, done_d;

  logic        is_digit, is_op, is_eq, digit_ok;
  logic [7:0]  cur;
  logic [11:0] prod;

  assign is_digit = IN_key_valid && (IN_key <= 4'd9);
  assign is_op    = IN_key_valid && (IN_key >= 4'hA) && (IN_key <= 4'hE);
  assign is_eq    = IN_key_valid && (IN_key == 4'hF);

  // Accumulate wide enough that 255*10+9 cannot wrap before the range check.
  assign cur      = (state_q == StEntryB) ? b_q : a_q;
  assign prod     = 12'(cur) * 12'd10 + 12'(IN_key);
  assign digit_ok = (cnt_q < 4'(MAX_DIGITS)) && (prod <= 12'd255);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    chain_d = chain_q;
    neg_d   = neg_q;
    lt_d    = lt_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (IN_clr) begin
      state_d = StEntryA;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      op_d    = '0;
      cs_d    = '0;
      cnt_d   = '0;
      cin_d   = 1'b0;
      chain_d = 1'b0;
      neg_d   = 1'b0;
      lt_d    = 1'b0;
      zero_d  = 1'b0;
      carry_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StEntryA: begin
          if (is_digit) begin
            if (digit_ok) begin
              a_d   = prod[7:0];
              cnt_d = cnt_q + 4'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (is_op) begin
            op_d    = IN_key;
            b_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            chain_d = 1'b0;
            state_d = StEntryB;
          end
        end
        StEntryB: begin
          if (is_digit) begin
            if (digit_ok) begin
              b_d   = prod[7:0];
              cnt_d = cnt_q + 4'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (is_op) begin
            // Operator only replaces the pending op before any B digit.
            if (cnt_q == 4'd0) begin
              op_d  = IN_key;
              err_d = 1'b0;
            end
          end else if (is_eq) begin
            cs_d    = op_q;
            cin_d   = CHAIN_CARRY && chain_q && ((op_q == OpAdd) || (op_q == OpSub)) && carry_q;
            state_d = StExec;
          end
        end
        StExec: begin
          res_d   = IN_alu_S;
          done_d  = 1'b1;
          cs_d    = '0;
          cin_d   = 1'b0;
          state_d = StResult;
          if (op_q == OpSub) begin
            neg_d   = IN_alu_carry;
            carry_d = IN_alu_carry;
            zero_d  = IN_alu_zero;
            lt_d    = 1'b0;
          end else if (op_q == OpCmp) begin
            // ALU forces zero low for cmp, so derive it from S here.
            lt_d   = IN_alu_carry;
            zero_d = (IN_alu_S == 8'd0);
            neg_d  = 1'b0;
          end else begin
            carry_d = IN_alu_carry;
            zero_d  = IN_alu_zero;
            neg_d   = 1'b0;
            lt_d    = 1'b0;
          end
        end
        StResult: begin
          if (is_digit) begin
            a_d     = {4'd0, IN_key};
            cnt_d   = 4'd1;
            state_d = StEntryA;
          end else if (is_op) begin
            a_d     = res_q;
            op_d    = IN_key;
            b_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            chain_d = 1'b1;
            state_d = StEntryB;
          end
        end
        default: state_d = StEntryA;
      endcase
    end
  end

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_q <= StEntryA;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      chain_q <= 1'b0;
      neg_q   <= 1'b0;
      lt_q    <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      chain_q <= chain_d;
      neg_q   <= neg_d;
      lt_q    <= lt_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    OUT_disp = a_q;
    unique case (state_q)
      StEntryA:         OUT_disp = a_q;
      StEntryB, StExec: OUT_disp = (cnt_q != 4'd0) ? b_q : a_q;
      StResult:         OUT_disp = res_q;
      default:          OUT_disp = a_q;
    endcase
  end

  assign OUT_alu_cs  = cs_q;
  assign OUT_alu_a   = a_q;
  assign OUT_alu_b   = b_q;
  assign OUT_alu_cin = cin_q;
  assign OUT_neg     = neg_q;
  assign OUT_lt      = lt_q;
  assign OUT_zero    = zero_q;
  assign OUT_carry   = carry_q;
  assign OUT_err     = err_q;
  assign OUT_busy    = (state_q == StExec);
  assign OUT_done    = done_q;

endmodule
